// File: rtl/ov7670_pkg.sv
// ov7670_pkg -- shared definitions for the OV7670 frame capture controller.
//   state_t            : controller state encoding
//   WRRST_CYCLES_DEF   : default OV_WRRST low-pulse length (SYS_CLK cycles)
//   TIMEOUT_CYCLES_DEF : default VSYNC watchdog limit (SYS_CLK cycles)
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SKIP  = 3'd1,
    ST_WTRIG = 3'd2,
    ST_WRST  = 3'd3,
    ST_WCAP  = 3'd4,
    ST_WAIT  = 3'd5
  } state_t;

  localparam int unsigned WRRST_CYCLES_DEF   = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 2000000;

endpackage

// File: rtl/ov7670_frame_ctrl_if.sv
// ov7670_frame_ctrl_if -- control/status bundle of the frame capture controller.
//   RUN_EN, MODE, SKIP_CNT : capture control from the host
//   OV_VSYNC               : raw camera VSYNC (asynchronous)
//   R_IDLE                 : FIFO reader has drained the frame
//   OV_WRRST, OV_WEN       : FIFO write reset (active-low) / write enable
//   WR_FRAME, BUSY         : frame-complete pulse / controller not idle
//   FRAME_CNT, ERR         : completed-frame count / watchdog pulse
// Modports: master = controller side, slave = host/camera side.
interface ov7670_frame_ctrl_if #(
  parameter int unsigned SKIP_W = 4,
  parameter int unsigned CNT_W  = 8
);

  logic              RUN_EN;
  logic              MODE;
  logic [SKIP_W-1:0] SKIP_CNT;
  logic              OV_VSYNC;
  logic              R_IDLE;
  logic              OV_WRRST;
  logic              OV_WEN;
  logic              WR_FRAME;
  logic              BUSY;
  logic [CNT_W-1:0]  FRAME_CNT;
  logic              ERR;

  modport master (
    input  RUN_EN, MODE, SKIP_CNT, OV_VSYNC, R_IDLE,
    output OV_WRRST, OV_WEN, WR_FRAME, BUSY, FRAME_CNT, ERR
  );

  modport slave (
    output RUN_EN, MODE, SKIP_CNT, OV_VSYNC, R_IDLE,
    input  OV_WRRST, OV_WEN, WR_FRAME, BUSY, FRAME_CNT, ERR
  );

endinterface

// File: rtl/ov7670_vsync_sync.sv
// ov7670_vsync_sync -- two-flop synchronizer plus rising-edge detector for
// the camera VSYNC pin. VS_RISE is a registered one-cycle pulse, high during
// the third SYS_CLK cycle after the pin edge.
//   SYS_CLK  : clock, rising edge
//   RST      : asynchronous active-high reset
//   VSYNC_IN : asynchronous VSYNC pin
//   VS_RISE  : synchronous rising-edge pulse
module ov7670_vsync_sync (
  input  logic SYS_CLK,
  input  logic RST,
  input  logic VSYNC_IN,
  output logic VS_RISE
);

  logic sync1, sync2, sync_d;

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync_d  <= 1'b0;
      VS_RISE <= 1'b0;
    end else begin
      sync1   <= VSYNC_IN;
      sync2   <= sync1;
      sync_d  <= sync2;
      VS_RISE <= sync2 & ~sync_d;
    end
  end

endmodule

// File: rtl/ov7670_frame_ctrl.sv
// ov7670_frame_ctrl -- OV7670 FIFO frame capture controller.
// Waits for VSYNC, optionally discards SKIP_CNT frames, pulses the FIFO write
// reset, enables FIFO writes for exactly one frame, then waits for the reader
// to drain before idling (single) or re-arming (continuous).
//   SYS_CLK : clock, rising edge
//   RST     : asynchronous active-high reset
//   bus     : ov7670_frame_ctrl_if.master (control, VSYNC, FIFO and status)
// Build option: define OV_FRAME_WDOG_EN to enable the VSYNC watchdog (ERR).
module ov7670_frame_ctrl
  import ov7670_pkg::*;
#(
  parameter int unsigned WRRST_CYCLES   = WRRST_CYCLES_DEF,
  parameter int unsigned SKIP_W         = 4,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  SYS_CLK,
  input  logic                  RST,
  ov7670_frame_ctrl_if.master   bus
);

  state_t            state;
  logic              vs_rise;
  logic [SKIP_W-1:0] skip_lat;
  logic [SKIP_W-1:0] skip_cnt;
  logic [3:0]        wr_cnt;

  ov7670_vsync_sync u_vsync (
    .SYS_CLK  (SYS_CLK),
    .RST      (RST),
    .VSYNC_IN (bus.OV_VSYNC),
    .VS_RISE  (vs_rise)
  );

  assign bus.BUSY = (state != ST_IDLE);

`ifdef OV_FRAME_WDOG_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt;
`else
  // Timeout limit has no effect without the watchdog; kept for a stable parameter list.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign bus.ERR = 1'b0;
`endif

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      state         <= ST_IDLE;
      bus.OV_WRRST  <= 1'b1;
      bus.OV_WEN    <= 1'b0;
      bus.WR_FRAME  <= 1'b0;
      bus.FRAME_CNT <= '0;
      skip_lat      <= '0;
      skip_cnt      <= '0;
      wr_cnt        <= '0;
`ifdef OV_FRAME_WDOG_EN
      bus.ERR       <= 1'b0;
      wd_cnt        <= '0;
`endif
    end else begin
      bus.WR_FRAME <= 1'b0;
`ifdef OV_FRAME_WDOG_EN
      bus.ERR      <= 1'b0;
      wd_cnt       <= '0;
`endif
      case (state)
        ST_IDLE: begin
          if (bus.RUN_EN) begin
            skip_lat <= bus.SKIP_CNT;
            skip_cnt <= '0;
            state    <= (bus.SKIP_CNT != '0) ? ST_SKIP : ST_WTRIG;
          end
        end
        ST_SKIP: begin
          if (vs_rise) begin
            if ((skip_cnt + SKIP_W'(1)) == skip_lat) state <= ST_WTRIG;
            else skip_cnt <= skip_cnt + SKIP_W'(1);
          end
        end
        ST_WTRIG: begin
          if (vs_rise) begin
            bus.OV_WRRST <= 1'b0;
            wr_cnt       <= 4'd1;
            state        <= ST_WRST;
          end
        end
        ST_WRST: begin
          if (wr_cnt == 4'(WRRST_CYCLES)) begin
            bus.OV_WRRST <= 1'b1;
            bus.OV_WEN   <= 1'b1;
            state        <= ST_WCAP;
          end else begin
            wr_cnt <= wr_cnt + 4'd1;
          end
        end
        ST_WCAP: begin
          if (vs_rise) begin
            bus.OV_WEN    <= 1'b0;
            bus.WR_FRAME  <= 1'b1;
            bus.FRAME_CNT <= bus.FRAME_CNT + CNT_W'(1);
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.R_IDLE) begin
            if (bus.MODE && bus.RUN_EN) begin
              skip_lat <= bus.SKIP_CNT;
              skip_cnt <= '0;
              state    <= (bus.SKIP_CNT != '0) ? ST_SKIP : ST_WTRIG;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          bus.OV_WEN   <= 1'b0;
          bus.OV_WRRST <= 1'b1;
          state        <= ST_IDLE;
        end
      endcase
`ifdef OV_FRAME_WDOG_EN
      // Watchdog overrides the case above. The counter clears by default every
      // cycle; it only advances while sitting in a watched state without a
      // vs_rise, and those states are only left on vs_rise, so every state
      // entry also starts from zero.
      if ((state == ST_SKIP || state == ST_WTRIG || state == ST_WCAP) && !vs_rise) begin
        if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          bus.ERR      <= 1'b1;
          bus.OV_WEN   <= 1'b0;
          bus.OV_WRRST <= 1'b1;
          state        <= ST_IDLE;
        end else begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ov7670_frame_ctrl.sv
module tb_ov7670_frame_ctrl;

  localparam int EV_WRRST = 0;  // value: OV_WRRST low length in cycles
  localparam int EV_WEN   = 1;  // value: OV_WEN high length in cycles
  localparam int EV_FRAME = 2;  // value: FRAME_CNT at the WR_FRAME pulse
  localparam int EV_ERR   = 3;  // value: 0

  typedef struct {
    int dut;
    int kind;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_en = 1'b0;
  logic mode = 1'b0;
  logic [3:0] skip = 4'd0;
  logic vsync = 1'b0;
  logic r_idle = 1'b0;

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  ov7670_frame_ctrl_if #(.SKIP_W(4), .CNT_W(8)) ifa ();
  ov7670_frame_ctrl_if #(.SKIP_W(4), .CNT_W(2)) ifb ();

  assign ifa.RUN_EN = run_en;  assign ifb.RUN_EN = run_en;
  assign ifa.MODE = mode;      assign ifb.MODE = mode;
  assign ifa.SKIP_CNT = skip;  assign ifb.SKIP_CNT = skip;
  assign ifa.OV_VSYNC = vsync; assign ifb.OV_VSYNC = vsync;
  assign ifa.R_IDLE = r_idle;  assign ifb.R_IDLE = r_idle;

  ov7670_frame_ctrl #(.WRRST_CYCLES(4), .SKIP_W(4), .CNT_W(8)) u_a (
    .SYS_CLK(clk), .RST(rst), .bus(ifa));
  ov7670_frame_ctrl #(.WRRST_CYCLES(4), .SKIP_W(4), .CNT_W(2), .TIMEOUT_CYCLES(100)) u_b (
    .SYS_CLK(clk), .RST(rst), .bus(ifb));

  logic       wrrst_s [2];
  logic       wen_s   [2];
  logic       wrf_s   [2];
  logic       err_s   [2];
  logic [7:0] fc_s    [2];
  assign wrrst_s[0] = ifa.OV_WRRST; assign wrrst_s[1] = ifb.OV_WRRST;
  assign wen_s[0]   = ifa.OV_WEN;   assign wen_s[1]   = ifb.OV_WEN;
  assign wrf_s[0]   = ifa.WR_FRAME; assign wrf_s[1]   = ifb.WR_FRAME;
  assign err_s[0]   = ifa.ERR;      assign err_s[1]   = ifb.ERR;
  assign fc_s[0]    = ifa.FRAME_CNT;
  assign fc_s[1]    = {6'b0, ifb.FRAME_CNT};

  function automatic string kname(input int k);
    case (k)
      EV_WRRST: return "wrrst_low";
      EV_WEN:   return "wen_high";
      EV_FRAME: return "wr_frame";
      default:  return "err";
    endcase
  endfunction

  task automatic expect_ev(input int d, input int kind, input int val);
    ev_t e;
    e.dut = d; e.kind = kind; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic expect_frame(input int cnt_a, input int cnt_b);
    for (int d = 0; d < 2; d++) begin
      expect_ev(d, EV_WRRST, 4);
      expect_ev(d, EV_WEN, 16);
      expect_ev(d, EV_FRAME, (d == 0) ? cnt_a : cnt_b);
    end
  endtask

  // Pops the oldest expectation for this DUT and compares it to the observed event.
  task automatic score(input int d, input int kind, input int val);
    int idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].dut == d) begin
        idx = i;
        break;
      end
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected_event dut%0d: got %s=%0d, required no event", d, kname(kind), val);
    end else begin
      if (exp_q[idx].kind != kind || exp_q[idx].val != val) begin
        errors++;
        $display("FAIL event dut%0d: got %s=%0d, required %s=%0d",
                 d, kname(kind), val, kname(exp_q[idx].kind), exp_q[idx].val);
      end
      exp_q.delete(idx);
    end
  endtask

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Monitor: turns DUT output activity into events for the scoreboard.
  int   lo_cnt [2];
  int   hi_cnt [2];
  logic prev_wrrst [2];
  logic prev_wen   [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        lo_cnt[d] = 0;
        hi_cnt[d] = 0;
        prev_wrrst[d] = 1'b1;
        prev_wen[d] = 1'b0;
      end else begin
        if (wrrst_s[d] == 1'b0) lo_cnt[d]++;
        else if (prev_wrrst[d] == 1'b0) begin
          score(d, EV_WRRST, lo_cnt[d]);
          lo_cnt[d] = 0;
        end
        if (wen_s[d] == 1'b1) hi_cnt[d]++;
        else if (prev_wen[d] == 1'b1) begin
          score(d, EV_WEN, hi_cnt[d]);
          hi_cnt[d] = 0;
        end
        if (wrf_s[d] == 1'b1) score(d, EV_FRAME, int'(fc_s[d]));
        if (err_s[d] == 1'b1) score(d, EV_ERR, 0);
        prev_wrrst[d] = wrrst_s[d];
        prev_wen[d] = wen_s[d];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // VSYNC rising edge, then 20 cycles until the task returns.
  task automatic vs_edge();
    vsync = 1'b1;
    step(4);
    vsync = 1'b0;
    step(16);
  endtask

  task automatic pulse_r_idle();
    r_idle = 1'b1;
    step(1);
    r_idle = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    int k;
    step(3);
    rst = 1'b0;
    step(1);

    // Reset state
    check("rst_wrrst_a", ifa.OV_WRRST, 1);  check("rst_wrrst_b", ifb.OV_WRRST, 1);
    check("rst_wen_a", ifa.OV_WEN, 0);      check("rst_wen_b", ifb.OV_WEN, 0);
    check("rst_wrframe_a", ifa.WR_FRAME, 0);
    check("rst_busy_a", ifa.BUSY, 0);       check("rst_busy_b", ifb.BUSY, 0);
    check("rst_cnt_a", ifa.FRAME_CNT, 0);   check("rst_cnt_b", ifb.FRAME_CNT, 0);
    check("rst_err_a", ifa.ERR, 0);         check("rst_err_b", ifb.ERR, 0);

    // Single frame
    mode = 1'b0; skip = 4'd0; run_en = 1'b1;
    step(2);
    check("single_busy", ifa.BUSY, 1);
    expect_frame(1, 1);
    vs_edge();
    vs_edge();
    run_en = 1'b0;
    check("single_wait_busy", ifa.BUSY, 1);
    pulse_r_idle();
    step(1);
    check("single_done_busy", ifa.BUSY, 0);
    check("single_cnt_a", ifa.FRAME_CNT, 1);

    // Skip two frames
    skip = 4'd2; run_en = 1'b1;
    step(2);
    expect_frame(2, 2);
    for (int i = 0; i < 4; i++) vs_edge();
    run_en = 1'b0;
    pulse_r_idle();
    step(1);
    check("skip_done_busy", ifa.BUSY, 0);
    skip = 4'd0;

    // Continuous, 5 frames
    do_reset();
    check("rst2_cnt_a", ifa.FRAME_CNT, 0);
    mode = 1'b1; run_en = 1'b1;
    step(2);
    for (int i = 1; i <= 5; i++) begin
      expect_frame(i, i % 4);
      vs_edge();
      vs_edge();
      if (i == 5) run_en = 1'b0;
      pulse_r_idle();
    end
    step(1);
    check("cont_cnt_a", ifa.FRAME_CNT, 5);
    check("cont_cnt_b_wrap", ifb.FRAME_CNT, 1);
    check("cont_done_busy", ifa.BUSY, 0);

    // RUN_EN dropped mid-capture, continuous mode
    run_en = 1'b1;
    step(2);
    expect_frame(6, 2);
    vs_edge();
    check("stop_wen_mid", ifa.OV_WEN, 1);
    run_en = 1'b0;
    vs_edge();
    check("stop_wait_busy", ifa.BUSY, 1);
    pulse_r_idle();
    step(1);
    check("stop_idle_busy", ifa.BUSY, 0);
    check("stop_cnt_a", ifa.FRAME_CNT, 6);

    // Reset mid-frame
    mode = 1'b0; run_en = 1'b1;
    step(2);
    expect_ev(0, EV_WRRST, 4);
    expect_ev(1, EV_WRRST, 4);
    vs_edge();
    check("rstmid_wen_before", ifa.OV_WEN, 1);
    rst = 1'b1;
    #1;
    check("rstmid_wen_a", ifa.OV_WEN, 0);  check("rstmid_wen_b", ifb.OV_WEN, 0);
    check("rstmid_cnt_a", ifa.FRAME_CNT, 0);
    check("rstmid_wrframe_a", ifa.WR_FRAME, 0);
    run_en = 1'b0;
    step(2);
    rst = 1'b0;
    step(5);
    check("rstmid_busy", ifa.BUSY, 0);

    // Watchdog: no VSYNC in WTRIG
    run_en = 1'b1;
`ifdef OV_FRAME_WDOG_EN
    expect_ev(1, EV_ERR, 0);
`endif
    k = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (ifb.ERR) begin
        k = i;
        check("wdog_idle_b", ifb.BUSY, 0);
        break;
      end
    end
    #1;
    run_en = 1'b0;
`ifdef OV_FRAME_WDOG_EN
    check("wdog_err_cycle", k, 101);
`else
    check("wdog_err_never", k, 0);
`endif
    check("wdog_a_still_busy", ifa.BUSY, 1);
    do_reset();

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing_event dut%0d: got none, required %s=%0d",
               exp_q[0].dut, kname(exp_q[0].kind), exp_q[0].val);
      void'(exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
